// File: rtl/ariane_pkg.sv
// ariane_pkg: core-wide configuration constants and shared types.
// BHT_UPDQ_DEPTH sizes the branch-history-table update queue.
package ariane_pkg;

  // Number of buffered resolved-branch updates ahead of the BHT.
  localparam int unsigned BHT_UPDQ_DEPTH = 8;

  // Update presented to the branch history table.
  typedef struct packed {
    logic                   valid;
    logic [riscv::VLEN-1:0] pc;
    logic                   taken;
  } bht_update_t;

endpackage

// File: rtl/riscv.sv
// riscv: architectural constants shared across the core.
package riscv;

  // Virtual address width; branch pcs are carried at this width.
  localparam int unsigned VLEN = 64;

endpackage

// File: rtl/bht_update_queue.sv
// bht_update_queue: elastic FIFO between the branch unit and the BHT update port.
// Captures resolved branches, drains at most one per cycle while the BHT is
// enabled, and drops (and counts) updates that arrive while full because the
// branch unit cannot stall.
// Optional build macro BHT_UPDQ_DEDUP_EN: discard an incoming update identical
// (pc and taken) to the newest queued entry instead of queueing it again.
module bht_update_queue
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH      = BHT_UPDQ_DEPTH,  // power of two, >= 2
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    debug_mode_i,
  input  logic                    enable_i,
  input  logic                    upd_valid_i,
  input  logic [riscv::VLEN-1:0]  upd_pc_i,
  input  logic                    upd_taken_i,
  output logic                    upd_ready_o,
  output bht_update_t             bht_update_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic [DROP_CNT_W-1:0]   drop_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Entry storage; one write port (tail) and one read port (head).
  logic [riscv::VLEN-1:0] pc_mem    [DEPTH];
  logic                   taken_mem [DEPTH];

  logic [PTR_W-1:0]      head_reg, head_next;
  logic [PTR_W-1:0]      tail_reg, tail_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic [DROP_CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

  logic is_full;
  logic is_empty;
  logic accept;
  logic is_dup;
  logic push;
  logic pop;
  logic drop;
  logic out_valid;

  assign is_full  = (count_reg == FULL_CNT);
  assign is_empty = (count_reg == '0);

  // An update is considered at all only outside debug mode and outside a flush.
  assign accept = upd_valid_i && !debug_mode_i && !flush_i;

`ifdef BHT_UPDQ_DEDUP_EN
  // Compare against the newest entry even if it is leaving this cycle, so a
  // tight loop produces a single BHT step per repeated outcome.
  logic [PTR_W-1:0] newest_ptr;
  assign newest_ptr = tail_reg - PTR_W'(1);
  assign is_dup = !is_empty
                  && (pc_mem[newest_ptr] == upd_pc_i)
                  && (taken_mem[newest_ptr] == upd_taken_i);
`else
  assign is_dup = 1'b0;
`endif

  // A duplicate is silently absorbed; it neither occupies a slot nor counts as a drop.
  assign push = accept && !is_dup && !is_full;
  // No bypass while full: the slot freed by a same-cycle pop is not reused.
  assign drop = accept && !is_dup && is_full;

  // The BHT consumes every cycle it is enabled, so presenting is popping.
  assign out_valid = !is_empty && enable_i && !flush_i;
  assign pop       = out_valid;

  assign bht_update_o = '{valid: out_valid,
                          pc:    pc_mem[head_reg],
                          taken: taken_mem[head_reg]};
  assign upd_ready_o  = !is_full;
  assign count_o      = count_reg;
  assign drop_cnt_o   = drop_cnt_reg;

  // Next-state for pointers, occupancy and the saturating drop counter.
  always_comb begin
    head_next     = head_reg;
    tail_next     = tail_reg;
    count_next    = count_reg;
    drop_cnt_next = drop_cnt_reg;

    if (drop && (drop_cnt_reg != '1)) begin
      drop_cnt_next = drop_cnt_reg + DROP_CNT_W'(1);
    end

    if (flush_i) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (push) begin
        tail_next = tail_reg + PTR_W'(1);
      end
      if (pop) begin
        head_next = head_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      drop_cnt_reg <= '0;
    end else begin
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      count_reg    <= count_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  // Entry write at the tail; contents need no reset since count gates every use.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      pc_mem[tail_reg]    <= upd_pc_i;
      taken_mem[tail_reg] <= upd_taken_i;
    end
  end

endmodule

// File: tb/tb_bht_update_queue.sv
// tb_bht_update_queue: directed scenarios plus randomized traffic, checked
// against a queue-based reference model of the update buffer.
module tb_bht_update_queue;
  import ariane_pkg::*;

  localparam int DEPTH = 8;
  localparam int DW    = 16;
`ifdef BHT_UPDQ_DEDUP_EN
  localparam int DUP_COUNT = 1;
`else
  localparam int DUP_COUNT = 2;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, debug_mode_i, enable_i, upd_valid_i, upd_taken_i;
  logic [63:0] upd_pc_i;
  logic        upd_ready_o;
  bht_update_t bht_update_o;
  logic [3:0]  count_o;
  logic [DW-1:0] drop_cnt_o;

  always #5 clk_i = ~clk_i;

  bht_update_queue #(.DEPTH(DEPTH), .DROP_CNT_W(DW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .debug_mode_i (debug_mode_i),
    .enable_i     (enable_i),
    .upd_valid_i  (upd_valid_i),
    .upd_pc_i     (upd_pc_i),
    .upd_taken_i  (upd_taken_i),
    .upd_ready_o  (upd_ready_o),
    .bht_update_o (bht_update_o),
    .count_o      (count_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: an ordered list of {pc, taken} plus a drop tally.
  logic [64:0] mq[$];
  int          mdrop = 0;

  // Per-cycle observation and expectation, captured before the clock edge.
  logic          obs_valid, obs_taken, obs_ready;
  logic [63:0]   obs_pc;
  logic [3:0]    obs_cnt;
  logic [DW-1:0] obs_drop;
  logic [86:0]   obs, exp;

  // Apply one cycle of inputs, sample outputs, then advance the model past the edge.
  task automatic drive(input logic rst, input logic fl, input logic dbg, input logic en,
                       input logic v, input logic [63:0] pc, input logic tk);
    logic        e_valid;
    logic [64:0] head;
    logic        full;
    logic        dup;
    rst_i = rst; flush_i = fl; debug_mode_i = dbg; enable_i = en;
    upd_valid_i = v; upd_pc_i = pc; upd_taken_i = tk;
    #1;
    obs_valid = bht_update_o.valid;
    obs_pc    = bht_update_o.pc;
    obs_taken = bht_update_o.taken;
    obs_cnt   = count_o;
    obs_ready = upd_ready_o;
    obs_drop  = drop_cnt_o;
    e_valid = (mq.size() != 0) && en && !fl;
    head    = (mq.size() != 0) ? mq[0] : 65'b0;
    exp = {e_valid, (e_valid ? head : 65'b0), 4'(mq.size()), (mq.size() != DEPTH), DW'(mdrop)};
    obs = {obs_valid, (obs_valid ? {obs_pc, obs_taken} : 65'b0), obs_cnt, obs_ready, obs_drop};
    @(posedge clk_i);
    if (rst) begin
      mq.delete();
      mdrop = 0;
    end else if (fl) begin
      mq.delete();
    end else begin
      full = (mq.size() == DEPTH);
      dup  = 1'b0;
`ifdef BHT_UPDQ_DEDUP_EN
      if (mq.size() != 0 && mq[mq.size()-1] == {pc, tk}) dup = 1'b1;
`endif
      if (e_valid) void'(mq.pop_front());
      if (v && !dbg && !dup) begin
        if (full) begin
          if (mdrop < (1 << DW) - 1) mdrop++;
        end else begin
          mq.push_back({pc, tk});
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 1, 1, 64'h123, 1);
    drive(1, 0, 0, 1, 1, 64'h456, 0);
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 0, 0, 1, 0, 64'h0, 0);
    checks++;
    if (obs_valid !== 1'b0 || obs_cnt !== 4'd0 || obs_ready !== 1'b1 || obs_drop !== '0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b count=%0d ready=%b drop=%0d required 0/0/1/0",
               obs_valid, obs_cnt, obs_ready, obs_drop);
    end
    drive(0, 0, 0, 1, 0, 64'h0, 0);
    checks++;
    if (obs_cnt !== 4'd0 || obs_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_nothing_queued got count=%0d valid=%b required 0/0", obs_cnt, obs_valid);
    end
  endtask

  task automatic test_ordering();
    logic [63:0] pcs[3];
    logic        tks[3];
    int          peak;
    pcs[0] = 64'h100; pcs[1] = 64'h104; pcs[2] = 64'h108;
    tks[0] = 1'b1;    tks[1] = 1'b0;    tks[2] = 1'b1;
    peak = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, (i < 3), (i < 3) ? pcs[i % 3] : 64'h0, (i < 3) ? tks[i % 3] : 1'b0);
      if (int'(obs_cnt) > peak) peak = int'(obs_cnt);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL ordering_model cyc=%0d got %h required %h", i, obs, exp);
      end
      if (i >= 1 && i <= 3) begin
        checks++;
        if (obs_valid !== 1'b1 || obs_pc !== pcs[i-1] || obs_taken !== tks[i-1]) begin
          failures++;
          $display("FAIL ordering_out cyc=%0d got v=%b pc=%h t=%b required 1 pc=%h t=%b",
                   i, obs_valid, obs_pc, obs_taken, pcs[i-1], tks[i-1]);
        end
      end
    end
    checks++;
    if (peak != 1) begin
      failures++;
      $display("FAIL ordering_peak got %0d required 1", peak);
    end
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 1, 64'h400 + 64'(4 * i), i[0]);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL hold_fill cyc=%0d got %h required %h", i, obs, exp);
      end
    end
    for (int k = 0; k < 9; k++) begin
      drive(0, 0, 0, 1, 0, 64'h0, 0);
      if (k == 0) begin
        checks++;
        if (obs_cnt !== 4'd8 || obs_ready !== 1'b0 || obs_drop !== DW'(2)) begin
          failures++;
          $display("FAIL hold_full got count=%0d ready=%b drop=%0d required 8/0/2",
                   obs_cnt, obs_ready, obs_drop);
        end
      end
      checks++;
      if (k < 8) begin
        if (obs_valid !== 1'b1 || obs_pc !== 64'h400 + 64'(4 * k)) begin
          failures++;
          $display("FAIL hold_drain k=%0d got v=%b pc=%h required 1 pc=%h",
                   k, obs_valid, obs_pc, 64'h400 + 64'(4 * k));
        end
      end else if (obs_valid !== 1'b0) begin
        failures++;
        $display("FAIL hold_empty got v=%b required 0", obs_valid);
      end
    end
  endtask

  task automatic test_concurrency();
    do_reset();
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 1, 64'h500 + 64'(4 * i), 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 64'h0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1, (i < 5), 64'h600 + 64'(4 * i), i[1]);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL concurrency_model cyc=%0d got %h required %h", i, obs, exp);
      end
      if (i < 5) begin
        checks++;
        if (obs_cnt !== 4'd3) begin
          failures++;
          $display("FAIL concurrency_count cyc=%0d got %0d required 3", i, obs_cnt);
        end
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 1, 64'h700 + 64'(4 * i), 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 64'h0, 0);
    drive(0, 1, 0, 1, 1, 64'hDEAD0, 1);
    checks++;
    if (obs_cnt !== 4'd5 || obs_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_cycle got count=%0d valid=%b required 5/0", obs_cnt, obs_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0, 64'h0, 0);
      checks++;
      if (obs_cnt !== 4'd0 || obs_drop !== DW'(2) || obs_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_after cyc=%0d got count=%0d drop=%0d valid=%b pc=%h required 0/2/0",
                 i, obs_cnt, obs_drop, obs_valid, obs_pc);
      end
    end
  endtask

  task automatic test_debug_dedup();
    do_reset();
    drive(0, 0, 1, 0, 1, 64'h200, 1);
    drive(0, 0, 0, 0, 0, 64'h0, 0);
    checks++;
    if (obs_cnt !== 4'd0) begin
      failures++;
      $display("FAIL debug_ignored got count=%0d required 0", obs_cnt);
    end
    drive(0, 0, 0, 0, 1, 64'h300, 1);
    drive(0, 0, 0, 0, 1, 64'h300, 1);
    drive(0, 0, 0, 0, 1, 64'h300, 0);
    checks++;
    if (obs_cnt !== 4'(DUP_COUNT)) begin
      failures++;
      $display("FAIL dedup_count got %0d required %0d", obs_cnt, DUP_COUNT);
    end
    drive(0, 0, 0, 0, 0, 64'h0, 0);
    checks++;
    if (obs_cnt !== 4'(DUP_COUNT + 1) || obs_drop !== '0) begin
      failures++;
      $display("FAIL dedup_distinct got count=%0d drop=%0d required %0d/0",
               obs_cnt, obs_drop, DUP_COUNT + 1);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 7),
            64'h1000 + 64'(4 * $urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL random_model cyc=%0d got %h required %h", i, obs, exp);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; debug_mode_i = 1'b0; enable_i = 1'b0;
    upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0;
    @(posedge clk_i);
    #1;
    test_reset();
    test_ordering();
    test_hold();
    test_concurrency();
    test_flush();
    test_debug_dedup();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
